// File: rtl/issue_pkg.sv
// Shared definitions for the instruction issue unit: opcodes, FSM encoding
// and the 16-bit instruction field layout.
package issue_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RA_MSB  = 12;
  localparam int RA_LSB  = 10;
  localparam int RB_MSB  = 9;
  localparam int RB_LSB  = 7;
  localparam int RC_MSB  = 6;
  localparam int RC_LSB  = 0;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [6:0] rc;
  } instr_t;

  function automatic logic [2:0] opcode_of(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/prog_buffer.sv
// Program store: DEPTH x 16 words, synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a mid-run reset.
module prog_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue_unit.sv
// Issues a host-loaded program word by word over a valid/ready port and
// captures the processor result for every accepted word.
module instr_issue_unit
  import issue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   count,
  output logic [15:0]   instruction,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic [15:0]   result,
  output logic [15:0]   result_q,
  output logic          result_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          halted
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic [AW:0]   remaining;
  logic [AW:0]   count_clamped;
  logic [15:0]   rd_data;
  logic          in_issue;
  logic          in_idle;
  logic          is_halt;
  logic          handshake;

  // Writes are only accepted while idle, so a running program cannot be altered.
  prog_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (load_en && in_idle),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  assign in_idle       = (state == ST_IDLE);
  assign in_issue      = (state == ST_ISSUE);
  assign is_halt       = (opcode_of(rd_data) == OP_HALT);
  assign count_clamped = (count > DEPTH_W) ? DEPTH_W : count;

  assign instruction = in_issue ? rd_data : 16'h0000;
  assign instr_valid = in_issue && !is_halt;
  assign handshake   = instr_valid && instr_ready;
  assign busy        = in_issue;
  assign done        = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      pc           <= '0;
      halted       <= 1'b0;
      result_q     <= 16'h0000;
      result_valid <= 1'b0;
    end else begin
      result_valid <= handshake;
      if (handshake) begin
        result_q <= result;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            halted <= 1'b0;
            pc     <= '0;
            if (count_clamped == '0) begin
              state <= ST_DONE;
            end else begin
              remaining <= count_clamped;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (is_halt) begin
            halted <= 1'b1;
            state  <= ST_DONE;
          end else if (handshake) begin
            remaining <= remaining - (AW+1)'(1);
            // pc stays on the final word so a full DEPTH run never wraps.
            if (remaining == (AW+1)'(1)) begin
              state <= ST_DONE;
            end else begin
              pc <= pc + AW'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit: directed programs push expected
// words/results; a negedge monitor pops and compares on each handshake/result.
module tb_instr_issue_unit;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   count = '0;
  logic [15:0]   instruction;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic [15:0]   result;
  logic [15:0]   result_q;
  logic          result_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          halted;

  instr_issue_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .count        (count),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .result       (result),
    .result_q     (result_q),
    .result_valid (result_valid),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Processor stand-in: ADD returns 50, anything else returns word+1.
  always_comb result = (instruction[15:13] == 3'b000) ? 16'd50 : instruction + 16'd1;

  typedef struct {
    logic [15:0]   w;
    logic [AW-1:0] p;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] res_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int rv_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  // Monitor
  logic        prev_stall = 1'b0;
  logic [15:0] prev_instr = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_instr", instruction, prev_instr);
        chk("stall_hold_valid", instr_valid, 1);
      end
      if (instruction == 16'hE000) chk("halt_never_valid", instr_valid, 0);
      if (instr_valid && instr_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) miss("unexpected_handshake");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("handshake pc=%0d instr=%04h (exp %04h)", pc, instruction, e.w);
          chk("hs_instruction", instruction, e.w);
          chk("hs_pc", pc, e.p);
        end
      end
      if (result_valid) begin
        rv_cnt++;
        if (res_q.size() == 0) miss("unexpected_result_valid");
        else begin
          logic [15:0] r;
          r = res_q.pop_front();
          $display("result result_q=%04h (exp %04h)", result_q, r);
          chk("result_q", result_q, r);
        end
      end
      if (done) done_cnt++;
      prev_stall = instr_valid && !instr_ready;
      prev_instr = instruction;
    end
  end

  task automatic push(input logic [15:0] w, input logic [AW-1:0] p, input logic [15:0] r);
    exp_t e;
    e.w = w;
    e.p = p;
    exp_q.push_back(e);
    res_q.push_back(r);
  endtask

  task automatic push_basic();
    push(16'h0082, 0, 16'd50);
    push(16'h2081, 1, 16'h2082);
    push(16'h4081, 2, 16'h4082);
    push(16'h6082, 3, 16'h6083);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic load_basic();
    load(0, 16'h0082);
    load(1, 16'h2081);
    load(2, 16'h4081);
    load(3, 16'h6082);
  endtask

  task automatic run(input string tag, input logic [AW:0] cnt, input int exp_k, input int exp_hs,
                     input logic exp_rv_done, input logic exp_halt,
                     input int stall_at, input int stall_len, input logic poke);
    int k;
    int hs0, rv0, d0;
    hs0 = hs_cnt;
    rv0 = rv_cnt;
    d0 = done_cnt;
    count = cnt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (k == 1) chk("first_valid", instr_valid, (cnt != 0));
      if (done) break;
      if (k >= 60) begin
        miss("run_timeout");
        break;
      end
      @(posedge clk);
      #1;
      instr_ready = !(stall_at != 0 && k + 1 >= stall_at && k + 1 < stall_at + stall_len);
      if (poke && k == 1) begin
        load_en = 1'b1;
        load_addr = 0;
        load_data = 16'hFFFF;
        start = 1'b1;
      end else begin
        load_en = 1'b0;
        start = 1'b0;
      end
    end
    load_en = 1'b0;
    start = 1'b0;
    instr_ready = 1'b1;
    chk("done_latency", k, exp_k);
    chk("rv_with_done", result_valid, exp_rv_done);
    chk("halted_at_done", halted, exp_halt);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("halted_held", halted, exp_halt);
    chk("hs_count", hs_cnt - hs0, exp_hs);
    chk("rv_count", rv_cnt - rv0, exp_hs);
    chk("done_count", done_cnt - d0, 1);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("run %s: cycles=%0d handshakes=%0d halted=%0d", tag, k, hs_cnt - hs0, halted);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instruction"}, instruction, 16'h0000);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_result_q"}, result_q, 16'h0000);
  endtask

  initial begin
    int hs0, d0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    load_basic();
    push_basic();
    run("basic", 4, 5, 4, 1, 0, 0, 0, 0);

    push_basic();
    run("backpressure", 4, 8, 4, 1, 0, 3, 3, 0);

    push_basic();
    run("ignored_inputs", 4, 5, 4, 1, 0, 0, 0, 1);
    push_basic();
    run("buffer_unchanged", 4, 5, 4, 1, 0, 0, 0, 0);

    load(2, 16'hE000);
    push(16'h0082, 0, 16'd50);
    push(16'h2081, 1, 16'h2082);
    run("halt", 4, 4, 2, 0, 1, 0, 0, 0);

    run("count0", 0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) begin
      load(AW'(i), 16'h2000 + 16'(i));
      push(16'h2000 + 16'(i), AW'(i), 16'h2001 + 16'(i));
    end
    run("count31", 31, 17, 16, 1, 0, 0, 0, 0);

    // Reset after two handshakes, then rerun from pc 0.
    load_basic();
    push_basic();
    hs0 = hs_cnt;
    d0 = done_cnt;
    count = 4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    chk("midrun_hs_count", hs_cnt - hs0, 2);
    exp_q.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_no_done", done_cnt - d0, 0);
    push_basic();
    run("after_reset", 4, 5, 4, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_issue_unit.md
# instr_issue_unit

Instruction issue unit: the producer end of the processor's 16-bit instruction port. It holds a small program buffer loaded by a host write port. On `start` it issues the stored words one at a time to the processor under a valid/ready handshake, and captures the processor's `result` for each accepted instruction. It sits between the test/host environment and `Processor`, replacing hand-driven instruction stimulus.

## Interface
- `DEPTH`, default 16: program buffer entries (power of two).
- `AW`, default 4: address width, equal to log2(`DEPTH`).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `load_en`  in  1: write `load_data` to buffer[`load_addr`]; honoured only in IDLE.
- `load_addr`  in  AW: buffer write address.
- `load_data`  in  16: instruction word.
- `start`  in  1: begin issuing; honoured only in IDLE.
- `count`  in  AW+1: number of words to issue; sampled with `start`; values above DEPTH are clamped to DEPTH.
- `instruction`  out  16: word presented to the processor.
- `instr_valid`  out  1: `instruction` is valid.
- `instr_ready`  in  1: processor accepts the word this cycle.
- `result`  in  16: processor result bus.
- `result_q`  out  16: captured result.
- `result_valid`  out  1: one-cycle pulse when `result_q` updates.
- `pc`  out  AW: index of the word currently presented.
- `busy`  out  1: high in ISSUE.
- `done`  out  1: one-cycle pulse on completion.
- `halted`  out  1: last run ended on a HALT opcode; held until the next `start`.

## Operation
- Instruction format: [15:13] opcode, [12:10] rA, [9:7] rB, [6:0] rC/imm.
  - Opcodes: 000 ADD, 001 ADDI, 010 SUBI, 011 SUB, 111 HALT.
  - Other opcodes are issued unchanged.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - `load_en` writes the buffer.
  - `start` with clamped `count` = 0 goes to DONE.
  - `start` with nonzero `count` goes to ISSUE, with `pc`=0, remaining=`count`, and `halted` cleared.
- ISSUE:
  - `instruction` = buffer[`pc`] (combinational read).
  - `instr_valid` = 1 unless buffer[`pc`][15:13] = 111.
  - Handshake (`instr_valid` & `instr_ready`):
    - Increment `pc` and decrement remaining.
    - If remaining reaches 0, go to DONE.
  - HALT word at `pc`: never issued; set `halted`; go to DONE next edge.
  - `instruction` holds stable while `instr_valid` is high and `instr_ready` is low.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Result capture:
  - The cycle after each accepted handshake, `result_q` <= `result` and `result_valid` pulses.
  - This also happens in DONE for the final instruction.
- Ignored inputs:
  - `start` and `load_en` in ISSUE or DONE are dropped, not queued.
  - `load_en` and `start` in the same IDLE cycle: the write happens first, so issue can use the new word.
- `pc` never wraps: the maximum issue run is DEPTH words, ending with `pc` = DEPTH-1 accepted.

## Timing
- Reset values:
  - state IDLE.
  - `instruction` = 16'h0000 (driven 0 outside ISSUE).
  - `instr_valid`, `busy`, `done`, `result_valid`, `halted` = 0.
  - `pc` = 0.
  - `result_q` = 0.
- Buffer contents are not reset.
- Latencies:
  - `start` -> first `instr_valid`: 1 cycle.
  - Throughput with `instr_ready` tied high: one word per cycle.
  - N accepted words: `done` is 1 cycle after the last handshake, coincident with the last `result_valid`.
- Reset asserted mid-ISSUE:
  - All outputs return to reset values immediately (asynchronously).
  - No `done` pulse and no `result_valid`.
  - Buffer contents are preserved.

## Structure
- Shared package `issue_pkg`:
  - opcode constants (OP_ADD=3'b000, OP_ADDI=3'b001, OP_SUBI=3'b010, OP_SUB=3'b011, OP_HALT=3'b111).
  - state encoding (IDLE, ISSUE, DONE).
  - instruction field bit positions.
- One natural sub-module: `prog_buffer`, with a synchronous write port and a combinational read port, DEPTH x 16.

## Test plan
- Basic run:
  - Load 16'h0082 (ADD r0=r1+r2), 16'h2081 (ADDI), 16'h4081 (SUBI), 16'h6082 (SUB); `instr_ready`=1; `start`, `count`=4.
  - Required: four consecutive valid cycles, `pc` 0..3, `done` one cycle after the 4th handshake, `halted`=0.
- Backpressure:
  - Same program, `instr_ready` low for 3 cycles on word 2.
  - Required: `instruction` holds 16'h4081 while stalled; exactly 4 handshakes and 4 `result_valid` pulses.
- HALT:
  - Word 2 = 16'hE000, `count`=4.
  - Required: 2 words issued, `instr_valid` never high with 16'hE000, `done` pulse, `halted`=1.
- Edge counts:
  - `count`=0 -> `done` 1 cycle after `start`, no `instr_valid`.
  - `count`=31 -> clamped to 16; 16 words issued.
- Result capture:
  - Processor model returns 16'd50 for the ADD.
  - Required: `result_q`=50 with `result_valid` one cycle after the ADD handshake.
- Reset and ignored inputs:
  - `start` and `load_en` during ISSUE are ignored and the buffer is unchanged.
  - `reset` after 2 handshakes -> outputs at reset values; a new `start` reissues from `pc`=0 with the buffer intact.
